// File: rtl/phy_free_list.sv
// ---------------------------------------------------------------------------
// phy_free_list
//   Free list of physical register ids for the rename stage. It is a
//   circular FIFO of NUM_PHY 7-bit ids. Rename pops ids from the head and
//   commit pushes released ids at the tail. One head checkpoint supports
//   branch mispredict recovery.
//
// Ports
//   clk           sole clock, rising edge
//   rst           synchronous active-high reset
//   alloc_req     rename consumes the offered id this cycle
//   alloc_id      {valid, id at head}; combinational from registered state
//   free_valid    commit returns a physical register
//   free_id       {valid, id} being returned; ignored unless bit 7 is set
//   ckpt_take     snapshot the (post-allocation) head pointer
//   ckpt_restore  roll head back to the snapshot
//   free_count    number of free entries, 0..NUM_PHY
//   empty         free_count == 0
//   overflow_err  sticky: a valid return was dropped because the list was full
// ---------------------------------------------------------------------------
module phy_free_list #(
  parameter int NUM_PHY  = 128,
  parameter int NUM_ARCH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alloc_req,
  output logic [7:0] alloc_id,
  input  logic       free_valid,
  input  logic [7:0] free_id,
  input  logic       ckpt_take,
  input  logic       ckpt_restore,
  output logic [7:0] free_count,
  output logic       empty,
  output logic       overflow_err
);

  // Pointers carry one extra wrap bit above the 7-bit index so that a
  // completely full list (tail - head == 128) is distinct from an empty one.
  logic [6:0] mem_reg [NUM_PHY];
  logic [7:0] head_reg;
  logic [7:0] head_next;
  logic [7:0] tail_reg;
  logic [7:0] tail_next;
  logic [7:0] ckpt_head_reg;
  logic       ckpt_valid_reg;
  logic       overflow_reg;

  logic [7:0] count;
  logic       non_empty;
  logic       alloc_fire;
  logic       free_try;
  logic       free_fire;
  logic       restore_fire;

  assign count     = tail_reg - head_reg;
  assign non_empty = (count != 8'd0);

  // A restore request always blocks allocation, even when no snapshot is held,
  // so the rename stage never consumes an id during a recovery cycle.
  assign alloc_fire   = alloc_req && non_empty && !ckpt_restore;
  assign free_try     = free_valid && free_id[7];
  // When full, a return is still accepted if an allocation frees a slot in the
  // same cycle.
  assign free_fire    = free_try && ((count < 8'(NUM_PHY)) || alloc_fire);
  assign restore_fire = ckpt_restore && ckpt_valid_reg;

  always_comb begin
    head_next = head_reg + {7'd0, alloc_fire};
    if (restore_fire) begin
      head_next = ckpt_head_reg;
    end
    tail_next = tail_reg + {7'd0, free_fire};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg       <= 8'd0;
      tail_reg       <= 8'(NUM_PHY - NUM_ARCH);
      ckpt_head_reg  <= 8'd0;
      ckpt_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      head_reg <= head_next;
      tail_reg <= tail_next;
      // Restore wins over a concurrent take and always leaves no snapshot.
      if (ckpt_restore) begin
        ckpt_valid_reg <= 1'b0;
      end else if (ckpt_take) begin
        ckpt_head_reg  <= head_next;
        ckpt_valid_reg <= 1'b1;
      end
      if (free_try && !free_fire) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Only the first NUM_PHY-NUM_ARCH slots hold meaningful ids after reset;
  // the rest are written before they are ever read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PHY - NUM_ARCH; i++) begin
        mem_reg[i] <= 7'(NUM_ARCH + i);
      end
    end else if (free_fire) begin
      mem_reg[tail_reg[6:0]] <= free_id[6:0];
    end
  end

  assign alloc_id     = {non_empty, mem_reg[head_reg[6:0]]};
  assign free_count   = count;
  assign empty        = !non_empty;
  assign overflow_err = overflow_reg;

endmodule

// File: tb/tb_phy_free_list.sv
module tb_phy_free_list;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_req;
  logic [7:0] alloc_id;
  logic       free_valid;
  logic [7:0] free_id;
  logic       ckpt_take;
  logic       ckpt_restore;
  logic [7:0] free_count;
  logic       empty;
  logic       overflow_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  // Scoreboard: ids expected to come out of the list, in order.
  logic [6:0] fl[$];

  phy_free_list #(.NUM_PHY(128), .NUM_ARCH(32)) dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_id(alloc_id),
    .free_valid(free_valid), .free_id(free_id), .ckpt_take(ckpt_take),
    .ckpt_restore(ckpt_restore), .free_count(free_count), .empty(empty),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    alloc_req = 1'b0; free_valid = 1'b0; free_id = 8'h00;
    ckpt_take = 1'b0; ckpt_restore = 1'b0;
  endtask

  // Apply one cycle of stimulus; outputs are examined 1 time unit after the edge.
  task automatic drive(input logic a, input logic fv, input logic [7:0] fid,
                       input logic tk, input logic rs);
    alloc_req = a; free_valid = fv; free_id = fid; ckpt_take = tk; ckpt_restore = rs;
    @(posedge clk); #1;
    clear_inputs();
    n_txn++;
    $display("txn %0d: alloc=%0b free=%0b id=%02h take=%0b restore=%0b -> alloc_id=%02h count=%0d ovf=%0b",
             n_txn, a, fv, fid, tk, rs, alloc_id, free_count, overflow_err);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    fl.delete();
    for (int i = 32; i < 128; i++) fl.push_back(7'(i));
  endtask

  task automatic test_reset();
    clear_inputs();
    do_reset();
    n_checks++; if (alloc_id !== 8'hA0) begin n_errors++; $display("FAIL reset_alloc_id: got %02h want a0", alloc_id); end
    n_checks++; if (free_count !== 8'd96) begin n_errors++; $display("FAIL reset_count: got %0d want 96", free_count); end
    n_checks++; if (empty !== 1'b0) begin n_errors++; $display("FAIL reset_empty: got %0b want 0", empty); end
    n_checks++; if (overflow_err !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %0b want 0", overflow_err); end
  endtask

  task automatic test_drain();
    logic [6:0] exp_id;
    do_reset();
    for (int k = 0; k < 96; k++) begin
      exp_id = fl.pop_front();
      n_checks++; if (alloc_id !== {1'b1, exp_id}) begin n_errors++; $display("FAIL drain_id[%0d]: got %02h want %02h", k, alloc_id, {1'b1, exp_id}); end
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    n_checks++; if (free_count !== 8'd0) begin n_errors++; $display("FAIL drain_count: got %0d want 0", free_count); end
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL drain_empty: got %0b want 1", empty); end
    n_checks++; if (alloc_id[7] !== 1'b0) begin n_errors++; $display("FAIL drain_valid: got %0b want 0", alloc_id[7]); end
  endtask

  task automatic test_empty_bypass();
    // Allocation from an empty list does nothing.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++; if (free_count !== 8'd0) begin n_errors++; $display("FAIL empty_alloc_count: got %0d want 0", free_count); end
    n_checks++; if (overflow_err !== 1'b0) begin n_errors++; $display("FAIL empty_alloc_ovf: got %0b want 0", overflow_err); end
    // Concurrent alloc+free on empty: return accepted, allocation not granted.
    drive(1'b1, 1'b1, 8'h85, 1'b0, 1'b0);
    n_checks++; if (free_count !== 8'd1) begin n_errors++; $display("FAIL bypass_count: got %0d want 1", free_count); end
    n_checks++; if (alloc_id !== 8'h85) begin n_errors++; $display("FAIL bypass_id: got %02h want 85", alloc_id); end
    n_checks++; if (empty !== 1'b0) begin n_errors++; $display("FAIL bypass_empty: got %0b want 0", empty); end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL bypass_drain_empty: got %0b want 1", empty); end
  endtask

  task automatic test_ckpt();
    logic [7:0] exp_id;
    do_reset();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (free_count !== 8'd96) begin n_errors++; $display("FAIL ckpt_take_count: got %0d want 96", free_count); end
    for (int k = 0; k < 3; k++) begin
      exp_id = 8'h80 | 8'(32 + k);
      n_checks++; if (alloc_id !== exp_id) begin n_errors++; $display("FAIL ckpt_alloc[%0d]: got %02h want %02h", k, alloc_id, exp_id); end
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    n_checks++; if (free_count !== 8'd93) begin n_errors++; $display("FAIL ckpt_pre_count: got %0d want 93", free_count); end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++; if (alloc_id !== 8'hA0) begin n_errors++; $display("FAIL ckpt_restore_id: got %02h want a0", alloc_id); end
    n_checks++; if (free_count !== 8'd96) begin n_errors++; $display("FAIL ckpt_restore_count: got %0d want 96", free_count); end
    // Restore without a snapshot: nothing moves and the allocation is blocked.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++; if (alloc_id !== 8'hA0) begin n_errors++; $display("FAIL ckpt_novalid_id: got %02h want a0", alloc_id); end
    n_checks++; if (free_count !== 8'd96) begin n_errors++; $display("FAIL ckpt_novalid_count: got %0d want 96", free_count); end
    // Take alongside an allocation snapshots the post-allocation head (id 33).
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (alloc_id !== 8'hA1) begin n_errors++; $display("FAIL ckpt_take_alloc_id: got %02h want a1", alloc_id); end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++; if (alloc_id !== 8'hA2) begin n_errors++; $display("FAIL ckpt_alloc2_id: got %02h want a2", alloc_id); end
    // Take+restore together: restore only, snapshot cleared.
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    n_checks++; if (alloc_id !== 8'hA1) begin n_errors++; $display("FAIL ckpt_both_id: got %02h want a1", alloc_id); end
    n_checks++; if (free_count !== 8'd95) begin n_errors++; $display("FAIL ckpt_both_count: got %0d want 95", free_count); end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++; if (alloc_id !== 8'hA2) begin n_errors++; $display("FAIL ckpt_cleared_id: got %02h want a2", alloc_id); end
    // Restore with a same-cycle return: both take effect.
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'h81, 1'b0, 1'b1);
    n_checks++; if (alloc_id !== 8'hA2) begin n_errors++; $display("FAIL ckpt_rs_free_id: got %02h want a2", alloc_id); end
    n_checks++; if (free_count !== 8'd95) begin n_errors++; $display("FAIL ckpt_rs_free_count: got %0d want 95", free_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b1, 8'h80 | 8'(i), 1'b0, 1'b0);
      fl.push_back(7'(i));
      if (i == 10) begin
        // Returns without the valid bit are ignored silently.
        drive(1'b0, 1'b1, 8'h0B, 1'b0, 1'b0);
        n_checks++; if (free_count !== 8'd107) begin n_errors++; $display("FAIL ovf_invalid_count: got %0d want 107", free_count); end
      end
    end
    n_checks++; if (free_count !== 8'd128) begin n_errors++; $display("FAIL ovf_full_count: got %0d want 128", free_count); end
    // Concurrent alloc+free at full: no error.
    n_checks++; if (alloc_id !== {1'b1, fl[0]}) begin n_errors++; $display("FAIL ovf_full_id: got %02h want %02h", alloc_id, {1'b1, fl[0]}); end
    drive(1'b1, 1'b1, 8'hC5, 1'b0, 1'b0);
    void'(fl.pop_front()); fl.push_back(7'h45);
    n_checks++; if (free_count !== 8'd128) begin n_errors++; $display("FAIL ovf_both_count: got %0d want 128", free_count); end
    n_checks++; if (overflow_err !== 1'b0) begin n_errors++; $display("FAIL ovf_both_err: got %0b want 0", overflow_err); end
    drive(1'b0, 1'b1, 8'h05, 1'b0, 1'b0);
    n_checks++; if (overflow_err !== 1'b0) begin n_errors++; $display("FAIL ovf_invalid_full_err: got %0b want 0", overflow_err); end
    drive(1'b0, 1'b1, 8'h80, 1'b0, 1'b0);
    n_checks++; if (overflow_err !== 1'b1) begin n_errors++; $display("FAIL ovf_err: got %0b want 1", overflow_err); end
    n_checks++; if (free_count !== 8'd128) begin n_errors++; $display("FAIL ovf_drop_count: got %0d want 128", free_count); end
    n_checks++; if (alloc_id !== {1'b1, fl[0]}) begin n_errors++; $display("FAIL ovf_next_id: got %02h want %02h", alloc_id, {1'b1, fl[0]}); end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    void'(fl.pop_front());
    n_checks++; if (overflow_err !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %0b want 1", overflow_err); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1; alloc_req = 1'b1; free_valid = 1'b1; free_id = 8'h81;
    ckpt_restore = 1'b1; ckpt_take = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; clear_inputs();
    n_checks++; if (alloc_id !== 8'hA0) begin n_errors++; $display("FAIL midrst_id: got %02h want a0", alloc_id); end
    n_checks++; if (free_count !== 8'd96) begin n_errors++; $display("FAIL midrst_count: got %0d want 96", free_count); end
    n_checks++; if (empty !== 1'b0) begin n_errors++; $display("FAIL midrst_empty: got %0b want 0", empty); end
    n_checks++; if (overflow_err !== 1'b0) begin n_errors++; $display("FAIL midrst_ovf: got %0b want 0", overflow_err); end
    // No snapshot survives reset: a restore must not move head.
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++; if (alloc_id !== 8'hA0) begin n_errors++; $display("FAIL midrst_ckpt_id: got %02h want a0", alloc_id); end
  endtask

  task automatic test_wrap();
    logic a, fv, af, ff, ov_model;
    logic [7:0] fid;
    do_reset();
    ov_model = 1'b0;
    for (int c = 0; c < 200; c++) begin
      a   = 1'($urandom_range(0, 1));
      fv  = ($urandom_range(0, 9) < 6);
      fid = {1'b1, 7'($urandom_range(0, 127))};
      n_checks++; if (free_count !== 8'(fl.size())) begin n_errors++; $display("FAIL wrap_count[%0d]: got %0d want %0d", c, free_count, fl.size()); end
      if (fl.size() != 0) begin
        n_checks++; if (alloc_id !== {1'b1, fl[0]}) begin n_errors++; $display("FAIL wrap_id[%0d]: got %02h want %02h", c, alloc_id, {1'b1, fl[0]}); end
      end
      af = a && (fl.size() != 0);
      ff = fv && ((fl.size() < 128) || af);
      if (fv && !ff) ov_model = 1'b1;
      if (af) void'(fl.pop_front());
      if (ff) fl.push_back(fid[6:0]);
      drive(a, fv, fid, 1'b0, 1'b0);
    end
    n_checks++; if (free_count !== 8'(fl.size())) begin n_errors++; $display("FAIL wrap_final_count: got %0d want %0d", free_count, fl.size()); end
    n_checks++; if (overflow_err !== ov_model) begin n_errors++; $display("FAIL wrap_ovf: got %0b want %0b", overflow_err, ov_model); end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    test_reset();
    test_drain();
    test_empty_bypass();
    test_ckpt();
    test_overflow();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
